// File: rtl/sd_host.sv
// sd_host: loads an 81-cell sudoku puzzle, streams it to an external solver,
// collects the solver's answers for the blank cells and checks the completed
// grid (rows, columns, boxes).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load_valid, load_data   puzzle load, one cell per cycle, row-major (0 = blank)
//   start                   run request (IDLE, 81 cells loaded, no load this cycle)
//   sd_in_valid, sd_in      cell stream to the solver
//   sd_out_valid, sd_out    answer stream from the solver (10 = unsolvable)
//   busy, done, result      run status; result 0 PASS .. 5 PROTOCOL
//   blank_cnt               blanks in the loaded puzzle (saturates at 31)
//
// Build option: define SD_HOST_TIMEOUT_EN to build the WAIT timeout counter
// (TIMEOUT_CYCLES); without it WAIT persists until the solver answers.
module sd_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  input  logic       start,
  output logic       sd_in_valid,
  output logic [3:0] sd_in,
  input  logic       sd_out_valid,
  input  logic [3:0] sd_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] result,
  output logic [4:0] blank_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_CHECK, S_FIN} state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("sd_host: TIMEOUT_CYCLES must be non-zero");
  end

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_buf  [81];
  logic [3:0]  r_work [81];
  logic [6:0]  r_bpos [16];   // positions of the first 16 blanks, in load order
  logic [6:0]  r_load_cnt, r_blank_cnt, r_idx;
  logic [4:0]  r_grp, r_rsp_cnt;
  logic        r_rsp_bad, r_rsp_has10, r_first10;
  logic [2:0]  r_result, w_res_nxt;
  logic        w_res_we, w_start_ok, w_puz_bad, w_rsp_val, w_grp_ok;
  logic [3:0]  w_cell [9];
  logic [8:0]  w_seen;

`ifdef SD_HOST_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] r_wait;
  logic              w_timeout;
  // Leaving WAIT on the edge where the counter would reach TIMEOUT_CYCLES.
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign w_start_ok  = (r_state == S_IDLE) && start && !load_valid && (r_load_cnt == 7'd81);
  assign w_puz_bad   = (r_blank_cnt == 7'd0) || (r_blank_cnt > 7'd15);
  assign w_rsp_val   = sd_out_valid && ((r_state == S_WAIT) || (r_state == S_RECV));

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FIN);
  assign sd_in_valid = (r_state == S_SEND);
  assign sd_in       = sd_in_valid ? r_buf[r_idx] : '0;
  assign result      = r_result;
  assign blank_cnt   = (r_blank_cnt > 7'd31) ? 5'd31 : r_blank_cnt[4:0];

  // Cell index of member k of group g: rows 0-8, columns 9-17, boxes 18-26.
  function automatic logic [6:0] cell_idx(input logic [4:0] g, input int unsigned k);
    int unsigned gi, bi, idx;
    gi = {27'd0, g};
    if (gi < 9) begin
      idx = gi * 9 + k;
    end else if (gi < 18) begin
      idx = k * 9 + (gi - 9);
    end else begin
      bi  = gi - 18;
      idx = ((bi / 3) * 3 + k / 3) * 9 + (bi % 3) * 3 + k % 3;
    end
    return idx[6:0];
  endfunction

  // Answers are range-checked before CHECK, so nine cells cover 1-9 only if
  // each digit appears exactly once.
  always_comb begin
    w_seen = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      w_cell[k] = r_work[cell_idx(r_grp, k)];
      if ((w_cell[k] >= 4'd1) && (w_cell[k] <= 4'd9)) w_seen[w_cell[k] - 4'd1] = 1'b1;
    end
    w_grp_ok = &w_seen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_res_we    = 1'b0;
    w_res_nxt   = r_result;
    case (r_state)
      S_IDLE:  if (w_start_ok) begin
                 if (w_puz_bad) begin
                   w_state_nxt = S_FIN; w_res_we = 1'b1; w_res_nxt = 3'd4;
                 end else begin
                   w_state_nxt = S_SEND;
                 end
               end
      S_SEND:  if (r_idx == 7'd80) w_state_nxt = S_WAIT;
      S_WAIT:  if (sd_out_valid) w_state_nxt = S_RECV;
`ifdef SD_HOST_TIMEOUT_EN
               else if (w_timeout) begin
                 w_state_nxt = S_FIN; w_res_we = 1'b1; w_res_nxt = 3'd3;
               end
`endif
      S_RECV:  if (!sd_out_valid) begin
                 w_res_we    = 1'b1;
                 w_state_nxt = S_FIN;
                 if ((r_rsp_cnt == 5'd1) && r_first10)
                   w_res_nxt = 3'd1;
                 else if (({2'b00, r_rsp_cnt} != r_blank_cnt) || r_rsp_bad || r_rsp_has10)
                   w_res_nxt = 3'd5;
                 else begin
                   w_res_we    = 1'b0;
                   w_state_nxt = S_CHECK;
                 end
               end
      S_CHECK: if (!w_grp_ok) begin
                 w_state_nxt = S_FIN; w_res_we = 1'b1; w_res_nxt = 3'd2;
               end else if (r_grp == 5'd26) begin
                 w_state_nxt = S_FIN; w_res_we = 1'b1; w_res_nxt = 3'd0;
               end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 81; i++) begin
        r_buf[i]  <= '0;
        r_work[i] <= '0;
      end
      for (int unsigned i = 0; i < 16; i++) r_bpos[i] <= '0;
      r_load_cnt  <= '0;
      r_blank_cnt <= '0;
      r_idx       <= '0;
      r_grp       <= '0;
      r_rsp_cnt   <= '0;
      r_rsp_bad   <= 1'b0;
      r_rsp_has10 <= 1'b0;
      r_first10   <= 1'b0;
      r_result    <= '0;
    end else begin
      if ((r_state == S_IDLE) && load_valid) begin
        if (r_load_cnt == 7'd81) begin
          r_buf[0]    <= load_data;
          r_load_cnt  <= 7'd1;
          r_blank_cnt <= (load_data == 4'd0) ? 7'd1 : 7'd0;
          r_bpos[0]   <= '0;
        end else begin
          r_buf[r_load_cnt] <= load_data;
          r_load_cnt        <= r_load_cnt + 7'd1;
          if (load_data == 4'd0) begin
            if (r_blank_cnt < 7'd16) r_bpos[r_blank_cnt[3:0]] <= r_load_cnt;
            r_blank_cnt <= r_blank_cnt + 7'd1;
          end
        end
      end
      if (w_start_ok) begin
        r_work      <= r_buf;
        r_idx       <= '0;
        r_grp       <= '0;
        r_rsp_cnt   <= '0;
        r_rsp_bad   <= 1'b0;
        r_rsp_has10 <= 1'b0;
        r_first10   <= 1'b0;
      end
      if (r_state == S_SEND)  r_idx <= r_idx + 7'd1;
      if (r_state == S_CHECK) r_grp <= r_grp + 5'd1;
      if (w_rsp_val) begin
        if (r_rsp_cnt < 5'd16) r_rsp_cnt <= r_rsp_cnt + 5'd1;
        if (r_rsp_cnt == 5'd0) r_first10 <= (sd_out == 4'd10);
        if ((sd_out == 4'd0) || (sd_out > 4'd10)) r_rsp_bad <= 1'b1;
        if (sd_out == 4'd10) r_rsp_has10 <= 1'b1;
        if ({2'b00, r_rsp_cnt} < r_blank_cnt) r_work[r_bpos[r_rsp_cnt[3:0]]] <= sd_out;
      end
      if (w_res_we)        r_result <= w_res_nxt;
      else if (w_start_ok) r_result <= '0;
    end
  end

`ifdef SD_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_wait <= '0;
    else if (r_state == S_WAIT) r_wait <= r_wait + 1'b1;
    else                       r_wait <= '0;
  end
`endif

endmodule

// File: tb/tb_sd_host.sv
module tb_sd_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       start = 1'b0;
  logic       sd_in_valid;
  logic [3:0] sd_in;
  logic       sd_out_valid = 1'b0;
  logic [3:0] sd_out = '0;
  logic       busy, done;
  logic [2:0] result;
  logic [4:0] blank_cnt;

  always #5 clk = ~clk;

  sd_host #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .start(start), .sd_in_valid(sd_in_valid), .sd_in(sd_in),
    .sd_out_valid(sd_out_valid), .sd_out(sd_out), .busy(busy), .done(done),
    .result(result), .blank_cnt(blank_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] g_sol [81];
  logic [3:0] g_puz [81];
  logic [3:0] g_rsp [$];
  int  g_delay = 0;
  bit  g_extra_start = 0;
  bit  g_noise = 0;

  task automatic make_solution();
    int perm [9];
    int j, t;
    for (int i = 0; i < 9; i++) perm[i] = i;
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g_sol[r*9+c] = 4'(perm[(r*3 + r/3 + c) % 9] + 1);
  endtask

  task automatic make_puzzle(input int nb);
    int cnt, p;
    for (int i = 0; i < 81; i++) g_puz[i] = g_sol[i];
    cnt = 0;
    while (cnt < nb) begin
      p = $urandom_range(0, 80);
      if (g_puz[p] != 0) begin g_puz[p] = 0; cnt++; end
    end
  endtask

  task automatic correct_rsp();
    g_rsp.delete();
    for (int i = 0; i < 81; i++) if (g_puz[i] == 0) g_rsp.push_back(g_sol[i]);
  endtask

  // Reference: outcome from the puzzle and the solver's answer list.
  function automatic int ref_result();
    int nb, j;
    logic [3:0] grid [81];
    logic [9:0] rm, cm, bm;
    nb = 0;
    for (int i = 0; i < 81; i++) if (g_puz[i] == 0) nb++;
    if (nb == 0 || nb > 15) return 4;
    if (g_rsp.size() == 0) return 3;
    if (g_rsp.size() == 1 && g_rsp[0] == 10) return 1;
    if (g_rsp.size() != nb) return 5;
    foreach (g_rsp[i]) if (g_rsp[i] < 1 || g_rsp[i] > 9) return 5;
    j = 0;
    for (int i = 0; i < 81; i++) begin
      if (g_puz[i] == 0) begin grid[i] = g_rsp[j]; j++; end
      else grid[i] = g_puz[i];
    end
    for (int u = 0; u < 9; u++) begin
      rm = '0; cm = '0; bm = '0;
      for (int v = 0; v < 9; v++) begin
        rm |= 10'd1 << grid[u*9+v];
        cm |= 10'd1 << grid[v*9+u];
        bm |= 10'd1 << grid[((u/3)*3 + v/3)*9 + (u%3)*3 + v%3];
      end
      if (rm[9:1] != 9'h1FF || cm[9:1] != 9'h1FF || bm[9:1] != 9'h1FF) return 2;
    end
    return 0;
  endfunction

  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk); load_valid = 1'b1; load_data = g_puz[i];
    end
    @(negedge clk); load_valid = 1'b0; load_data = '0;
  endtask

  task automatic do_run(input string tag);
    int exp_res, nb, exp_sent, sent, ri, idle, last_v, end_cyc, done_cyc;
    bit got, busy_bad, stream_bad, zero_bad;
    logic [2:0] res;
    logic [4:0] exp_bc;
    nb = 0;
    for (int i = 0; i < 81; i++) if (g_puz[i] == 0) nb++;
    exp_res  = ref_result();
    exp_sent = (nb >= 1 && nb <= 15) ? 81 : 0;
    exp_bc   = (nb > 31) ? 5'd31 : 5'(nb);
    n_vec++;
    if (blank_cnt !== exp_bc) begin
      n_err++; $display("FAIL %s blank_cnt: got %0d expected %0d", tag, blank_cnt, exp_bc);
    end
    sent = 0; ri = 0; idle = 0; last_v = -1; end_cyc = -1; done_cyc = -1;
    got = 0; busy_bad = 0; stream_bad = 0; zero_bad = 0; res = '0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (sd_in_valid === 1'b1) begin
        if (sent >= 81 || sd_in !== g_puz[sent]) stream_bad = 1;
        sent++; last_v = cyc;
      end else if (sd_in !== 4'd0) zero_bad = 1;
      if (done === 1'b1) begin got = 1; done_cyc = cyc; res = result; end
      start = g_extra_start && (cyc == 10);
      if (got) begin
        sd_out_valid = 1'b0; sd_out = '0;
      end else if (sd_in_valid === 1'b1) begin
        sd_out_valid = g_noise; sd_out = g_noise ? 4'($urandom_range(0, 15)) : 4'd0;
      end else if (sent > 0) begin
        idle++;
        if (idle > g_delay && ri < g_rsp.size()) begin
          sd_out_valid = 1'b1; sd_out = g_rsp[ri]; ri++;
        end else begin
          if (sd_out_valid) end_cyc = cyc;
          sd_out_valid = 1'b0; sd_out = '0;
        end
      end
      if (!got) @(negedge clk);
    end
    start = 1'b0; sd_out_valid = 1'b0; sd_out = '0;
    n_vec++;
    if (!got) begin n_err++; $display("FAIL %s done_seen: got 0 expected 1", tag); end
    n_vec++;
    if (res !== 3'(exp_res)) begin
      n_err++; $display("FAIL %s result: got %0d expected %0d", tag, res, exp_res);
    end
    n_vec++;
    if (sent != exp_sent) begin
      n_err++; $display("FAIL %s sd_in_count: got %0d expected %0d", tag, sent, exp_sent);
    end
    n_vec++;
    if ({stream_bad, zero_bad} !== 2'b00) begin
      n_err++; $display("FAIL %s sd_in_data: got stream_err=%0d idle_nonzero=%0d expected 0 0", tag, stream_bad, zero_bad);
    end
    n_vec++;
    if (busy_bad) begin n_err++; $display("FAIL %s busy_during_run: got low expected high", tag); end
    if (exp_res == 3) begin
      n_vec++;
      if (done_cyc - last_v != 17) begin
        n_err++; $display("FAIL %s timeout_latency: got %0d expected 17", tag, done_cyc - last_v);
      end
    end
    if (exp_res == 2) begin
      n_vec++;
      if (end_cyc < 0 || done_cyc - end_cyc < 1 || done_cyc - end_cyc > 27) begin
        n_err++; $display("FAIL %s check_latency: got %0d expected 1..27", tag, done_cyc - end_cyc);
      end
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00 || result !== res) begin
      n_err++; $display("FAIL %s post_done: got busy=%0d done=%0d result=%0d expected 0 0 %0d", tag, busy, done, result, res);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({sd_in_valid, sd_in, busy, done, result, blank_cnt} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {sd_in_valid, sd_in, busy, done, result, blank_cnt});
    end
    rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL start_unloaded: got busy=%0d done=%0d expected 0 0", busy, done);
    end
  endtask

  task automatic test_pass();
    make_solution(); make_puzzle(3); load_range(0, 80);
    correct_rsp(); g_delay = $urandom_range(0, 5);
    do_run("pass3");
  endtask

  task automatic test_unsolvable();
    g_rsp = '{4'd10}; g_delay = 2;
    do_run("unsolvable");
  endtask

  task automatic test_wrong();
    g_rsp = '{4'd4, 4'd4, 4'd4}; g_delay = 1;
    do_run("wrong");
  endtask

  task automatic test_bad_puzzle();
    make_solution(); make_puzzle(0); load_range(0, 80);
    g_rsp.delete();
    do_run("zero_blanks");
    make_puzzle(16); load_range(0, 80);
    do_run("sixteen_blanks");
  endtask

  task automatic test_timeout();
    make_solution(); make_puzzle(5); load_range(0, 80);
`ifdef SD_HOST_TIMEOUT_EN
    g_rsp.delete();
    do_run("timeout");
`else
    correct_rsp(); g_delay = 60;
    do_run("long_wait");
`endif
  endtask

  task automatic test_protocol();
    make_solution(); make_puzzle(3); load_range(0, 80);
    g_delay = 0;
    correct_rsp(); void'(g_rsp.pop_back()); do_run("proto_short");
    correct_rsp(); g_rsp[1] = 4'd0;  do_run("proto_zero");
    correct_rsp(); g_rsp[0] = 4'd12; do_run("proto_12");
    g_rsp = '{4'd10, 4'd10, 4'd10};  do_run("proto_multi10");
    correct_rsp();
    while (g_rsp.size() < 17) g_rsp.push_back(4'($urandom_range(1, 9)));
    do_run("proto_long");
  endtask

  task automatic test_back_to_back();
    make_solution(); make_puzzle(4); load_range(0, 80);
    g_rsp = '{4'd4, 4'd4, 4'd4, 4'd4}; g_delay = 0;
    do_run("b2b_first");
    correct_rsp(); g_extra_start = 1; g_noise = 1; g_delay = 3;
    do_run("b2b_reissue");
    g_extra_start = 0; g_noise = 0;
  endtask

  task automatic test_random();
    int kind, p;
    for (int n = 0; n < 6; n++) begin
      make_solution(); make_puzzle($urandom_range(1, 15)); load_range(0, 80);
      correct_rsp(); g_delay = $urandom_range(0, 8);
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        p = $urandom_range(0, g_rsp.size() - 1); g_rsp[p] = 4'($urandom_range(1, 9));
      end else if (kind == 2) begin
        g_rsp = '{4'd10};
      end else if (kind == 3) begin
        void'(g_rsp.pop_front());
      end
      do_run("random");
    end
  endtask

  task automatic test_reset_midrun();
    make_solution(); make_puzzle(3); load_range(0, 80);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (sd_in_valid !== 1'b1) begin n_err++; $display("FAIL midrun_sending: got %0d expected 1", sd_in_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({sd_in_valid, sd_in, busy, done, result, blank_cnt} !== '0) begin
      n_err++; $display("FAIL midrun_reset_outputs: got %h expected 0", {sd_in_valid, sd_in, busy, done, result, blank_cnt});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL start_after_reset: got busy=%0d done=%0d expected 0 0", busy, done);
    end
    load_range(0, 79);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start_80_loaded: got busy=%0d expected 0", busy); end
    load_valid = 1'b1; load_data = g_puz[80]; start = 1'b1;
    @(negedge clk); load_valid = 1'b0; load_data = '0; start = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start_with_load: got busy=%0d expected 0", busy); end
    correct_rsp(); g_delay = 0;
    do_run("reloaded");
  endtask

  initial begin
    test_reset();
    test_pass();
    test_unsolvable();
    test_wrong();
    test_bad_puzzle();
    test_timeout();
    test_protocol();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
